bit_pattern_gen: RTL
====================

// Module: bit_pattern_gen
// PURPOSE
//   Sequential source of test words for the all-zero/all-one bit detector.
//   On a start command it emits a programmed number of pattern words on a
//   valid/ready bus: all-zero, all-one, walking-one or walking-zero.
//   Sits in front of the detector in drill benches and self-test paths.
// PARAMETERS
//   WIDTH  32  data word width in bits (>= 2)
//   CNT_W   8  width of the word-count input; max run = 2**CNT_W-1 words
// PORTS
//   clk        in   1        single clock; all logic on posedge
//   reset      in   1        synchronous, active-high reset
//   start      in   1        begin a run; sampled only in IDLE
//   mode       in   2        00 all-zero, 01 all-one, 10 walking-one, 11 walking-zero
//   count      in   CNT_W    number of words to emit in the run
//   out_data   out  WIDTH    current pattern word
//   out_valid  out  1        out_data is valid
//   out_ready  in   1        consumer accepts word when out_valid & out_ready
//   busy       out  1        high in RUN and DONE
//   done       out  1        one-cycle pulse at end of run
// BEHAVIOUR
//   - Reset (sync, active-high): state=IDLE; out_data=0, out_valid=0,
//     busy=0, done=0 on the next posedge. Reset mid-run aborts the run at
//     once; no done pulse is generated for the aborted run.
//   - FSM states: IDLE, RUN, DONE.
//     IDLE -> RUN  : start=1 and count!=0; mode and count latched.
//     IDLE -> DONE : start=1 and count==0; no words emitted.
//     RUN  -> DONE : accept (valid&ready) of the last word.
//     DONE -> IDLE : unconditionally after one cycle; done=1 only in DONE.
//   - Latency: first word valid on the cycle after start is sampled.
//   - First word per mode: 00 -> all 0s; 01 -> all 1s;
//     10 -> 0x...0001; 11 -> ~0x...0001.
//   - On each accept: remaining count decrements; walking modes rotate
//     out_data left by 1. Wrap: MSB wraps back to bit 0 (0x80000000 ->
//     0x00000001 for WIDTH=32). Constant modes hold the word.
//   - Backpressure: while out_valid & !out_ready, out_data and the
//     remaining count are held stable; out_valid stays high.
//   - out_valid deasserts on the cycle after the last accept (out_data holds
//     the last word; it is don't-care when out_valid=0).
//   - start while busy is ignored; mode/count changes during a run ignored.
//   - start asserted in the DONE cycle is ignored; the earliest restart is
//     sampled in IDLE.
//   - Remaining counter is CNT_W bits; no overflow is possible.
// STRUCTURE
//   - Package bit_pattern_pkg: mode encodings (MODE_ZERO, MODE_ONE,
//     MODE_WALK1, MODE_WALK0) and FSM state encoding (ST_IDLE, ST_RUN,
//     ST_DONE).
//   - Sub-module bit_pattern_word: combinational first-word / next-word
//     function of (mode, current word), parameterised by WIDTH.
//   - Top holds the FSM, the latched mode, the remaining counter and the
//     data register.
// TESTING
//   1. mode=01, count=3, ready=1 -> three words 0xFFFFFFFF on consecutive
//      cycles; done pulses the cycle after the 3rd accept; busy then drops.
//   2. mode=10, count=33, ready=1 -> words 0x00000001, 0x00000002, ...,
//      0x80000000; 33rd word = 0x00000001 (wrap).
//   3. mode=11, count=4, ready low for cycles 2-4 -> word 0xFFFFFFFE held
//      with valid=1 while stalled; words FFFFFFFE, FFFFFFFD, FFFFFFFB,
//      FFFFFFF7 in order, none lost or duplicated.
//   4. mode=00, count=0, start=1 -> out_valid never asserts; done pulses
//      once on the cycle after start.
//   5. mode=10, count=10; assert reset after 4 accepts -> next cycle
//      out_valid=0, busy=0, out_data=0; no done pulse; new start works.
//   6. Start run count=5; pulse start with mode=01 mid-run -> ignored;
//      exactly 5 original-mode words, then a single done.

Source files
------------

// File: rtl/bit_pattern_pkg.sv
// Shared encodings for the bit pattern generator.
//   patMode_t  : pattern selection presented on the 2-bit mode input
//   fsmState_t : control FSM states of the generator
package bit_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_ZERO  = 2'b00,
        MODE_ONE   = 2'b01,
        MODE_WALK1 = 2'b10,
        MODE_WALK0 = 2'b11
    } patMode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } fsmState_t;

endpackage

// File: rtl/bit_pattern_word.sv
// Combinational pattern word function.
//   mode      in  : pattern selection
//   curWord   in  : word currently on the bus
//   firstWord out : opening word of a run for this mode
//   nextWord  out : word that follows curWord once it is accepted
module bit_pattern_word
    import bit_pattern_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  patMode_t           mode,
    input  logic [WIDTH-1:0]   curWord,
    output logic [WIDTH-1:0]   firstWord,
    output logic [WIDTH-1:0]   nextWord
);

    localparam logic [WIDTH-1:0] LSB_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        firstWord = '0;
        nextWord  = curWord;
        case (mode)
            MODE_ZERO:  firstWord = '0;
            MODE_ONE:   firstWord = '1;
            MODE_WALK1: firstWord = LSB_ONE;
            MODE_WALK0: firstWord = ~LSB_ONE;
            default:    firstWord = '0;
        endcase
        // Rotating left covers both walking modes: the single odd bit
        // moves up one place and the MSB wraps back to bit 0.
        if (mode == MODE_WALK1 || mode == MODE_WALK0)
            nextWord = {curWord[WIDTH-2:0], curWord[WIDTH-1]};
    end

endmodule

// File: rtl/bit_pattern_gen.sv
// Bit pattern generator: on start, emits `count` pattern words on a
// valid/ready bus, then pulses done for one cycle.
//   clk, reset : clock, synchronous active-high reset
//   start      : begin a run (sampled in IDLE only)
//   mode       : 00 zero, 01 one, 10 walking-one, 11 walking-zero
//   count      : number of words in the run (0 -> straight to done)
//   out_data   : current pattern word
//   out_valid  : out_data is valid
//   out_ready  : consumer accepts the word when valid & ready
//   busy       : high in RUN and DONE
//   done       : one-cycle end-of-run pulse
module bit_pattern_gen
    import bit_pattern_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    fsmState_t        state, nextState;
    patMode_t         modeQ;
    logic [CNT_W-1:0] remQ;
    logic [WIDTH-1:0] dataQ;
    logic [WIDTH-1:0] firstWord, nextWord;
    patMode_t         wordMode;
    logic             startRun, startEmpty, accept, lastAccept;

    assign startRun   = (state == ST_IDLE) && start && (count != '0);
    assign startEmpty = (state == ST_IDLE) && start && (count == '0);
    assign accept     = (state == ST_RUN) && out_ready;
    assign lastAccept = accept && (remQ == CNT_W'(1));

    // In IDLE the word function sees the live mode input so the first word
    // can be loaded on the start cycle; during a run it sees the latched mode.
    assign wordMode = (state == ST_IDLE) ? patMode_t'(mode) : modeQ;

    bit_pattern_word #(.WIDTH(WIDTH)) uWord (
        .mode      (wordMode),
        .curWord   (dataQ),
        .firstWord (firstWord),
        .nextWord  (nextWord)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= nextState;
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: begin
                if (startRun)        nextState = ST_RUN;
                else if (startEmpty) nextState = ST_DONE;
            end
            ST_RUN:  if (lastAccept) nextState = ST_DONE;
            ST_DONE: nextState = ST_IDLE;
            default: nextState = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        out_valid = (state == ST_RUN);
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
    end

    assign out_data = dataQ;

    // Datapath: latched mode, remaining count and current word
    always_ff @(posedge clk) begin
        if (reset) begin
            modeQ <= MODE_ZERO;
            remQ  <= '0;
            dataQ <= '0;
        end else if (startRun) begin
            modeQ <= patMode_t'(mode);
            remQ  <= count;
            dataQ <= firstWord;
        end else if (accept) begin
            remQ <= remQ - CNT_W'(1);
            // The last word stays on the bus after the run ends.
            if (!lastAccept) dataQ <= nextWord;
        end
    end

endmodule
